if_fetch_stage: RTL and testbench

Instruction-fetch stage that drives the PC register.
- Reads the current PC from the PC register and computes the next PC, and the PC-register stall.
- Runs the instruction-memory request/response handshake.
- Loads the IF/ID pipeline register, including a one-entry hold buffer for responses that arrive while decode is stalled.
- Applies branch redirects from ID, and flushes wrong-path instructions.

---
 rtl/if_pkg.sv | 7 +
 rtl/if_fetch_stage_ifid_reg.sv | 27 ++
 rtl/if_fetch_stage.sv | 76 +++++++
 tb/tb_if_fetch_stage.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
package if_pkg;
   typedef enum logic [1:0] {FETCH, HOLD, DROP, HALTED} state_t;
   localparam int PC_INC = 2;
   localparam int DATA_W_DEF = 16;
   localparam logic [3:0] HALT_OPC_DEF = 4'hF;
endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register (instr, pc2, valid); flush beats hold, hold beats load.
module ifid_reg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              flush,
   input  logic              hold,
   input  logic [DATA_W-1:0] instr,
   input  logic [DATA_W-1:0] pc2,
   output logic [DATA_W-1:0] instr_q,
   output logic [DATA_W-1:0] pc2_q,
   output logic              valid_q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         instr_q <= '0;
         pc2_q   <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (!hold) begin
         valid_q <= load;
         if (load) {instr_q, pc2_q} <= {instr, pc2};
      end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch FSM, next-PC mux and one-entry hold buffer feeding IF/ID.
// HLT detection is enabled by defining IF_HALT_DETECT_EN.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter int          DATA_W   = DATA_W_DEF,
   parameter logic [3:0]  HALT_OPC = HALT_OPC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pc_cur,
   output logic [DATA_W-1:0] pc_next,
   output logic              pc_stall,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              stall_id,
   input  logic              redirect_valid,
   input  logic [DATA_W-1:0] redirect_pc,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [DATA_W-1:0] ifid_pc2,
   output logic              ifid_valid,
   output logic              halted
);
`ifdef IF_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif
   state_t            state, nxt;
   logic [DATA_W-1:0] hold_buf, pc_inc, src;
   logic              fire, is_halt;
   assign pc_inc    = pc_cur + DATA_W'(PC_INC);
   assign src       = (state == HOLD) ? hold_buf : imem_rdata;
   assign is_halt   = HALT_EN && (src[DATA_W-1 -: 4] == HALT_OPC);
   assign halted    = HALT_EN && (state == HALTED);
   assign imem_req  = state == FETCH;
   assign imem_addr = pc_cur;
   // an instruction enters IF/ID from either the live response or the hold buffer
   assign fire      = !redirect_valid && !stall_id &&
                      ((state == FETCH && imem_valid) || state == HOLD);
   always_comb begin
      nxt      = state;
      pc_stall = !(redirect_valid || (fire && !is_halt));
      pc_next  = pc_stall ? pc_cur : redirect_valid ? redirect_pc : pc_inc;
      if (redirect_valid)
         nxt = ((state == FETCH || state == DROP) && !imem_valid) ? DROP : FETCH;
      else if (fire)
         nxt = is_halt ? HALTED : FETCH;
      else if (state == FETCH && imem_valid)
         nxt = HOLD;
      else if (state == DROP && imem_valid)
         nxt = FETCH;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= FETCH;
         hold_buf <= '0;
      end else begin
         state <= nxt;
         if (state == FETCH && imem_valid && stall_id && !redirect_valid) hold_buf <= imem_rdata;
      end
   ifid_reg #(.DATA_W(DATA_W)) u_ifid (
      .clk     (clk),
      .rst     (rst),
      .load    (fire),
      .flush   (redirect_valid),
      .hold    (stall_id),
      .instr   (src),
      .pc2     (pc_inc),
      .instr_q (ifid_instr),
      .pc2_q   (ifid_pc2),
      .valid_q (ifid_valid)
   );
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: random-latency memory, external PC register and an in-order fetch-stream model.
module tb_if_fetch_stage;
   logic        clk = 1'b0, rst = 1'b1;
   logic [15:0] pc_cur, pc_next, imem_addr, imem_rdata, redirect_pc, ifid_instr, ifid_pc2;
   logic        pc_stall, imem_req, imem_valid, stall_id, redirect_valid, ifid_valid, halted;
   int          n_tests = 0, n_fail = 0;
   bit          owed, wrong, m_valid, m_avail, m_halt;
   int          wait_c;
   logic [15:0] o_addr, m_pc, m_instr, m_pc2;

   if_fetch_stage dut (
      .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .pc_stall(pc_stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
      .imem_rdata(imem_rdata), .stall_id(stall_id), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .ifid_instr(ifid_instr), .ifid_pc2(ifid_pc2),
      .ifid_valid(ifid_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge rst)
      if (rst) pc_cur <= '0;
      else if (!pc_stall) pc_cur <= pc_next;

   function automatic logic [15:0] mem_of(input logic [15:0] a);
      logic [15:0] d;
      d = (a * 16'h9E37) ^ 16'h5A5A;
      if (d[15:12] == 4'hF) d[15] = 1'b0;
`ifdef IF_HALT_DETECT_EN
      if (a == 16'h0020) d = 16'hF000;
`endif
      return d;
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      owed = 0; wrong = 0; m_valid = 0; m_avail = 0; m_halt = 0; m_pc = '0;
   endtask

   // one clock: drive at negedge, predict from the fetch-stream rules, check after the edge
   task automatic step(input bit stl, input bit rdv, input logic [15:0] rpc, input int lat);
      bit          vld, good, dlv, hlt, es;
      logic [15:0] d, epn;
      check("imem_req", 16'(imem_req), 16'(!m_avail && !(owed && wrong) && !m_halt));
      if (imem_req) check("imem_addr", imem_addr, m_pc);
      if (!owed && imem_req) begin
         owed = 1; wait_c = lat; o_addr = imem_addr; wrong = 0;
      end
      vld = owed && wait_c == 0;
      imem_valid = vld;
      imem_rdata = vld ? mem_of(o_addr) : 16'($urandom);
      stall_id = stl; redirect_valid = rdv; redirect_pc = rpc;
      good = vld && !wrong;
      dlv = !rdv && !stl && !m_halt && (m_avail || good);
      d = mem_of(m_pc);
      hlt = dlv && d[15:12] == 4'hF;
      es = !(rdv || (dlv && !hlt));
      epn = rdv ? rpc : es ? m_pc : m_pc + 16'd2;
      #1;
      check("pc_next", pc_next, epn);
      check("pc_stall", 16'(pc_stall), 16'(es));
      check("halted", 16'(halted), 16'(m_halt));
      if (rdv) begin
         m_valid = 0; m_avail = 0; m_halt = 0; m_pc = rpc;
         if (owed && !vld) wrong = 1;
      end else if (dlv) begin
         m_instr = d; m_pc2 = m_pc + 16'd2; m_valid = 1; m_avail = 0;
         if (hlt) m_halt = 1;
         else m_pc = m_pc + 16'd2;
      end else if (stl) begin
         if (good) m_avail = 1;
      end else m_valid = 0;
      if (vld) owed = 0;
      else if (owed) wait_c--;
      @(posedge clk);
      #1;
      check("ifid_valid", 16'(ifid_valid), 16'(m_valid));
      if (m_valid) begin
         check("ifid_instr", ifid_instr, m_instr);
         check("ifid_pc2", ifid_pc2, m_pc2);
      end
      check("pc_cur", pc_cur, m_pc);
      @(negedge clk);
   endtask

   // asynchronous reset pulse away from any clock edge
   task automatic do_reset();
      #2 rst = 1'b1;
      imem_valid = 0; stall_id = 0; redirect_valid = 0;
      #1;
      check("rst_valid", 16'(ifid_valid), 16'h0);
      check("rst_halted", 16'(halted), 16'h0);
      check("rst_pc", pc_cur, 16'h0);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] rp;
      imem_valid = 0; imem_rdata = '0; stall_id = 0; redirect_valid = 0; redirect_pc = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_valid", 16'(ifid_valid), 16'h0);
      check("reset_pc", pc_cur, 16'h0);
      rst = 1'b0;
      repeat (3) step(0, 0, 16'h0, 0);
      step(0, 1, 16'h0010, 0);
      repeat (5) step(0, 0, 16'h0, 3);
      step(1, 0, 16'h0, 0);
      step(1, 0, 16'h0, 0);
      repeat (2) step(0, 0, 16'h0, 0);
      step(0, 0, 16'h0, 3);
      step(0, 1, 16'h0100, 3);
      repeat (8) step(0, 0, 16'h0, 2);
      step(0, 1, 16'hFFFE, 0);
      repeat (3) step(0, 0, 16'h0, 0);
      step(0, 1, 16'h0020, 0);
      repeat (4) step(0, 0, 16'h0, 0);
      step(1, 0, 16'h0, 0);
      step(0, 1, 16'h0040, 0);
      repeat (3) step(0, 0, 16'h0, 0);
      step(0, 1, 16'h0020, 1);
      repeat (4) step(0, 0, 16'h0, 1);
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rp = 16'($urandom) & 16'hFFFE;
         if ($urandom_range(0, 7) == 0) rp = 16'hFFFA;
         if ($urandom_range(0, 7) == 0) rp = 16'h0020;
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rp, int'($urandom_range(0, 3)));
         if ($urandom_range(0, 199) == 0) do_reset();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
